fir_tf_param: RTL

Parametrised transposed-form FIR filter, the successor to the fixed 16-tap 8-bit FIR in the comparison kernels. It generalises data width, coefficient width and tap count. It adds a runtime-loadable coefficient bank, valid-gated sample flow and a synchronous flush, and emits full-precision signed results with no overflow. It sits in the DSP datapath between the sample source and downstream accumulation and decimation logic.

---
 rtl/fir_tf_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fir_tf_param.sv
// Parametrised transposed-form FIR filter with a runtime-loadable
// coefficient bank, valid-gated sample flow and a synchronous flush.
// Results are full-precision signed values; there is no rounding or
// saturation because OUT_W is wide enough for the worst-case sum.
module fir_tf_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS),
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] Xin,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  Yout
);

  // Coefficient bank H[0..TAPS-1]
  logic signed [COEF_W-1:0] h_q [TAPS];
  logic signed [COEF_W-1:0] h_d [TAPS];

  // Partial-sum registers Q[1..TAPS-1]; Q[TAPS-1] feeds the output adder
  logic signed [OUT_W-1:0]  q_q [1:TAPS-1];
  logic signed [OUT_W-1:0]  q_d [1:TAPS-1];

  // Products of the current sample with every coefficient
  logic signed [OUT_W-1:0]  prod [TAPS];

  logic signed [OUT_W-1:0]  yout_q, yout_d;
  logic                     vld_q, vld_d;
  logic                     accept;
  logic                     addr_ok;

  // Sign-extend both operands to OUT_W before multiplying so the product
  // is exact in the output width.
  function automatic logic signed [OUT_W-1:0] mul_ext(
    input logic signed [COEF_W-1:0] h,
    input logic signed [DATA_W-1:0] x
  );
    logic signed [OUT_W-1:0] he;
    logic signed [OUT_W-1:0] xe;
    he = {{(OUT_W-COEF_W){h[COEF_W-1]}}, h};
    xe = {{(OUT_W-DATA_W){x[DATA_W-1]}}, x};
    return he * xe;
  endfunction

  // A flush discards any coincident sample.
  assign accept = in_valid & ~flush;

  // Writes to addresses beyond the last tap are dropped; when TAPS is a
  // power of two every encodable address is a real tap.
  if ((1 << AW) > TAPS) begin : g_addr_chk
    assign addr_ok = (coef_addr < AW'(TAPS));
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  // Products always use the coefficients held before this edge's write.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = mul_ext(h_q[k], Xin);
    end
  end

  // Coefficient bank next state: single addressed write per cycle.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      h_d[k] = h_q[k];
    end
    if (coef_we && addr_ok) begin
      h_d[coef_addr] = coef_data;
    end
  end

  // Transposed-form update of the partial sums and output on accepted
  // samples; flush zeroes the history but leaves Yout holding.
  always_comb begin
    for (int j = 1; j < TAPS; j++) begin
      q_d[j] = q_q[j];
    end
    yout_d = yout_q;
    vld_d  = accept;
    if (flush) begin
      for (int j = 1; j < TAPS; j++) begin
        q_d[j] = '0;
      end
    end else if (in_valid) begin
      q_d[1] = prod[TAPS-1];
      for (int j = 2; j < TAPS; j++) begin
        q_d[j] = q_q[j-1] + prod[TAPS-j];
      end
      yout_d = q_q[TAPS-1] + prod[0];
    end
  end

  // ---- register stage: coefficients, partial sums, output ----
  // State registers; reset restores an identity filter with empty history.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < TAPS; k++) begin
        h_q[k] <= '0;
      end
      h_q[0] <= COEF_W'(1);
      for (int j = 1; j < TAPS; j++) begin
        q_q[j] <= '0;
      end
      yout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        h_q[k] <= h_d[k];
      end
      for (int j = 1; j < TAPS; j++) begin
        q_q[j] <= q_d[j];
      end
      yout_q <= yout_d;
      vld_q  <= vld_d;
    end
  end

  assign Yout      = yout_q;
  assign out_valid = vld_q;

endmodule
